// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, parity
// selectors and the per-bit tick count derived from CTRL.BAUD.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // BAUD=3 is the fastest rate; each step down doubles the bit length.
  function automatic int bit_ticks(input int base_div, input logic [1:0] baud);
    return base_div << (2'd3 - baud);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX byte FIFO. Pointers carry an extra wrap bit so full and
// empty fall straight out of the registered pointers.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign rdata = mem[rptr[AW-1:0]];

  // Pointer update; a push into a full FIFO is refused even if a pop lands the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: buffers CSR-pushed bytes and serialises them as
// start / 8 data LSB-first / optional parity / stop at the latched bit rate.
module uart_tx_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int BASE_DIV   = 16,
  parameter int PARITY     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_wen,
  input  logic [7:0] fifo_wdata,
  output logic       fifo_wready,
  input  logic [1:0] baud,
  input  logic       txen,
  input  logic       txst,
  input  logic       lp_en,
  input  logic [7:0] lp_div,
  output logic       busy_en,
  output logic       busy,
  output logic       txf,
  output logic       tx_set,
  output logic       tx
);
  import uart_pkg::*;

  // Wide enough to hold the slowest bit length, BASE_DIV << 3.
  localparam int CW = $clog2(BASE_DIV * 8) + 1;

  tx_state_e   state, state_nxt;
  logic        full, empty, pop;
  logic [7:0]  rdata, shift;
  logic        par_bit;
  logic [2:0]  bit_cnt;
  logic [CW-1:0] bt_l, tick_cnt;
  logic        lp_en_l;
  logic [7:0]  lp_div_l, pre;
  logic        armed;
  logic        tick, bit_end, can_start, stop_end, tx_nxt;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_wen),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  assign fifo_wready = !full;
  assign txf         = full;

  assign tick      = !lp_en_l || (pre == lp_div_l);
  assign bit_end   = tick && (tick_cnt == bt_l - 1'b1);
  assign can_start = armed && txen && !empty;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next state, next line level and pop strobe; a pop always opens a frame.
  always_comb begin
    state_nxt = state;
    tx_nxt    = tx;
    pop       = 1'b0;
    stop_end  = 1'b0;
    case (state)
      ST_IDLE: if (can_start) begin
        state_nxt = ST_START;
        tx_nxt    = 1'b0;
        pop       = 1'b1;
      end
      ST_START: if (bit_end) begin
        state_nxt = ST_DATA;
        tx_nxt    = shift[0];
      end
      ST_DATA: if (bit_end) begin
        if (bit_cnt != 3'd7) begin
          tx_nxt = shift[1];
        end else if (PARITY != PARITY_NONE) begin
          state_nxt = ST_PARITY;
          tx_nxt    = par_bit;
        end else begin
          state_nxt = ST_STOP;
          tx_nxt    = 1'b1;
        end
      end
      ST_PARITY: if (bit_end) begin
        state_nxt = ST_STOP;
        tx_nxt    = 1'b1;
      end
      ST_STOP: if (bit_end) begin
        stop_end = 1'b1;
        if (can_start) begin
          state_nxt = ST_START;
          tx_nxt    = 1'b0;
          pop       = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
          tx_nxt    = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  // Datapath: frame config latch, shifter, prescaler/tick counter, status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx       <= 1'b1;
      busy     <= 1'b0;
      busy_en  <= 1'b0;
      tx_set   <= 1'b0;
      armed    <= 1'b0;
      shift    <= '0;
      par_bit  <= 1'b0;
      bit_cnt  <= '0;
      bt_l     <= '0;
      tick_cnt <= '0;
      lp_en_l  <= 1'b0;
      lp_div_l <= '0;
      pre      <= '0;
    end else begin
      tx <= tx_nxt;

      if (pop) begin
        shift    <= rdata;
        par_bit  <= (PARITY == PARITY_ODD) ? ~^rdata : ^rdata;
        bit_cnt  <= '0;
        bt_l     <= CW'(bit_ticks(BASE_DIV, baud));
        lp_en_l  <= lp_en;
        lp_div_l <= lp_div;
      end else if (state == ST_DATA && bit_end) begin
        shift   <= shift >> 1;
        bit_cnt <= bit_cnt + 1'b1;
      end

      // Prescaler restarts at every frame so bit edges stay aligned to START.
      if (pop || tick) pre <= '0;
      else             pre <= pre + 1'b1;

      if (pop || bit_end)                tick_cnt <= '0;
      else if (tick && state != ST_IDLE) tick_cnt <= tick_cnt + 1'b1;

      busy    <= (state_nxt != ST_IDLE);
      busy_en <= ((state_nxt != ST_IDLE) != busy);
      tx_set  <= stop_end && empty;

      // txen low dominates; a drained return to IDLE disarms before txst can re-arm.
      if (!txen)                                        armed <= 1'b0;
      else if (stop_end && state_nxt == ST_IDLE && empty) armed <= 1'b0;
      else if (txst)                                    armed <= 1'b1;
    end
  end

endmodule
